// File: rtl/pattern_generator_if.sv
// Pixel-side bundle of the test-pattern source: coordinates and mode request in, RGBI and status out.
interface pattern_generator_if #(
    parameter int unsigned COLOR_W = 3
) ();
    logic               video_on;
    logic [9:0]         pixel_x;
    logic [9:0]         pixel_y;
    logic [1:0]         mode_sel;
    logic [COLOR_W-1:0] color;
    logic               intensity;
    logic [1:0]         mode;
    logic [7:0]         frame_count;

    // Timing/coordinate generator side
    modport master (
        output video_on, pixel_x, pixel_y, mode_sel,
        input  color, intensity, mode, frame_count
    );

    // Pattern generator side
    modport slave (
        input  video_on, pixel_x, pixel_y, mode_sel,
        output color, intensity, mode, frame_count
    );
endinterface

// File: rtl/pattern_generator.sv
// VGA test-pattern source: four frame-synchronous patterns, horizontal scroll,
// frame counter, 2-stage registered output blanked by a delayed video_on.
module pattern_generator #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned NUM_BARS    = 8,
    parameter int unsigned COLOR_W     = 3,
    parameter int unsigned CHECK_LOG2  = 5,
    parameter int unsigned SCROLL_STEP = 4
) (
    input logic                clk,
    input logic                reset,
    pattern_generator_if.slave bus
);
    localparam int unsigned BAR_W  = H_ACTIVE / NUM_BARS;
    localparam int unsigned BAR_H  = V_ACTIVE / NUM_BARS;
    localparam int unsigned HALF_W = H_ACTIVE / 2;
    localparam int unsigned HALF_H = V_ACTIVE / 2;

    // Bar index as a compare chain against multiples of the bar size
    function automatic logic [COLOR_W-1:0] bar_index(input logic [9:0] v, input int unsigned size);
        logic [COLOR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 1; i < NUM_BARS; i++) begin
            if (v >= 10'(i * size)) idx = COLOR_W'(i);
        end
        return idx;
    endfunction

    logic               origin_q;
    logic [1:0]         mode_q;
    logic [7:0]         frame_count_q;
    logic [9:0]         scroll_q;

    logic               origin_c;
    logic               fs_c;
    logic [1:0]         mode_next_c;
    logic [10:0]        step_sum_c;
    logic [10:0]        step_wrap_c;
    logic [9:0]         scroll_next_c;
    logic [10:0]        x_sum_c;
    logic [10:0]        x_wrap_c;
    logic [9:0]         xe_c;

    logic [9:0]         xe_s1;
    logic [9:0]         y_s1;
    logic [1:0]         mode_s1;
    logic               von_s1;

    logic [COLOR_W-1:0] color_c;
    logic               intensity_c;
    logic [COLOR_W-1:0] color_q;
    logic               intensity_q;

    // Frame-start detect plus next mode/scroll, so the fs pixel already uses them
    always_comb begin
        origin_c      = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);
        fs_c          = origin_c && !origin_q;
        mode_next_c   = fs_c ? bus.mode_sel : mode_q;
        step_sum_c    = {1'b0, scroll_q} + 11'(SCROLL_STEP);
        step_wrap_c   = (step_sum_c >= 11'(H_ACTIVE)) ? step_sum_c - 11'(H_ACTIVE) : step_sum_c;
        scroll_next_c = (fs_c && (bus.mode_sel == 2'd3)) ? step_wrap_c[9:0] : scroll_q;
        x_sum_c       = {1'b0, bus.pixel_x} + {1'b0, scroll_next_c};
        x_wrap_c      = (x_sum_c >= 11'(H_ACTIVE)) ? x_sum_c - 11'(H_ACTIVE) : x_sum_c;
        // Only mode 3 scrolls; other modes see the raw column
        xe_c          = (mode_next_c == 2'd3) ? x_wrap_c[9:0] : bus.pixel_x;
    end

    // Frame-level state: edge history, active mode, frame counter, scroll offset
    always_ff @(posedge clk) begin
        if (reset) begin
            origin_q      <= 1'b0;
            mode_q        <= 2'd0;
            frame_count_q <= 8'd0;
            scroll_q      <= 10'd0;
        end else begin
            origin_q <= origin_c;
            scroll_q <= scroll_next_c;
            if (fs_c) begin
                mode_q        <= bus.mode_sel;
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    // Pipeline stage 1: effective x, line, mode and video_on
    always_ff @(posedge clk) begin
        if (reset) begin
            xe_s1   <= 10'd0;
            y_s1    <= 10'd0;
            mode_s1 <= 2'd0;
            von_s1  <= 1'b0;
        end else begin
            xe_s1   <= xe_c;
            y_s1    <= bus.pixel_y;
            mode_s1 <= mode_next_c;
            von_s1  <= bus.video_on;
        end
    end

    // Pattern selection from stage-1 values
    always_comb begin
        color_c     = '0;
        intensity_c = 1'b0;
        case (mode_s1)
            2'd0, 2'd3: begin
                color_c     = bar_index(xe_s1, BAR_W);
                intensity_c = (y_s1 >= 10'(HALF_H));
            end
            2'd1: begin
                color_c     = bar_index(y_s1, BAR_H);
                intensity_c = (xe_s1 >= 10'(HALF_W));
            end
            default: begin
                color_c     = (xe_s1[CHECK_LOG2] ^ y_s1[CHECK_LOG2]) ? '1 : '0;
                intensity_c = 1'b1;
            end
        endcase
    end

    // Pipeline stage 2: registered RGBI with blanking
    always_ff @(posedge clk) begin
        if (reset) begin
            color_q     <= '0;
            intensity_q <= 1'b0;
        end else begin
            color_q     <= von_s1 ? color_c : '0;
            intensity_q <= von_s1 & intensity_c;
        end
    end

    assign bus.color       = color_q;
    assign bus.intensity   = intensity_q;
    assign bus.mode        = mode_q;
    assign bus.frame_count = frame_count_q;
endmodule

// File: doc/pattern_generator.md
# pattern_generator

Parametrised VGA test-pattern source. Sits between the sync/pixel-coordinate generator and the RGBI output pins. It maps `pixel_x`/`pixel_y` to a colour index plus an intensity bit. It supports four selectable patterns, a frame-synchronous mode switch, a per-frame horizontal scroll, and a frame counter. Output is a 2-stage registered pipeline, blanked by a delayed copy of `video_on`.

## Interface
- `H_ACTIVE`, 640: active pixels per line. Must be divisible by `NUM_BARS`.
- `V_ACTIVE`, 480: active lines per frame. Must be divisible by `NUM_BARS`.
- `NUM_BARS`, 8: number of bars in the bar patterns, 2..2^`COLOR_W`.
- `COLOR_W`, 3: width of the colour index.
- `CHECK_LOG2`, 5: log2 of the checkerboard square size in pixels.
- `SCROLL_STEP`, 4: pixels advanced per frame in scroll mode, 0..`H_ACTIVE`-1.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `video_on` in 1: high while in the active display area.
- `pixel_x` in 10: current column. May hold for several `clk` cycles.
- `pixel_y` in 10: current line.
- `mode_sel` in 2: requested pattern. Sampled only at frame start.
- `color` out `COLOR_W`: colour index, 0 when blanked.
- `intensity` out 1: intensity bit, 0 when blanked.
- `mode` out 2: currently active pattern.
- `frame_count` out 8: frames seen since reset, wraps at 256.

## Operation
- **Frame start (`fs`):** one-cycle internal strobe.
  - Asserted when (`pixel_x`==0 && `pixel_y`==0) is true this cycle and was false last cycle.
  - Only one `fs` per frame, even if the coordinates hold for several cycles.
  - The first cycle after reset counts as "last cycle false".
- **On `fs`:**
  - `mode` <= `mode_sel`.
  - `frame_count` <= `frame_count`+1, 8-bit wrap.
  - If the new `mode`==3: `scroll` <= `scroll`+`SCROLL_STEP`. If the sum ≥ `H_ACTIVE`, subtract `H_ACTIVE`.
  - Otherwise `scroll` holds.
- **Scroll arithmetic:** `scroll` is a 10-bit register. All sums are computed in 11 bits before the wrap compare.
- **Effective x:** xs = `pixel_x`+`scroll`, minus `H_ACTIVE` if ≥ `H_ACTIVE`.
  - Same 11-bit rule as above.
  - Only valid while `video_on`=1 (`pixel_x` < `H_ACTIVE`).
- **Bar index:**
  - bx = xs / (`H_ACTIVE`/`NUM_BARS`).
  - by = `pixel_y` / (`V_ACTIVE`/`NUM_BARS`).
  - Implemented as generated compare chains; no dividers.
- **Patterns.** The `mode` used is the value registered at the most recent `fs`.
  - Mode 0, vertical bars: `color`=bx computed with `scroll` forced to 0; `intensity` = (`pixel_y` ≥ `V_ACTIVE`/2).
  - Mode 1, horizontal bars: `color`=by; `intensity` = (`pixel_x` ≥ `H_ACTIVE`/2).
  - Mode 2, checkerboard: `color` = all ones if `pixel_x`[`CHECK_LOG2`] ^ `pixel_y`[`CHECK_LOG2`], else 0; `intensity`=1.
  - Mode 3, scrolling bars: `color`=bx using `scroll`; `intensity` as in mode 0.
- **Blanking:** when the pipeline-aligned `video_on` is 0, `color`=0 and `intensity`=0.
- **Reset values:**
  - `color`=0, `intensity`=0, `mode`=0, `frame_count`=0.
  - `scroll`=0, pipeline registers and delayed `video_on` cleared.
  - Reset asserted mid-frame clears all of the above on the next edge. The first `fs` after release follows the edge rule above.

## Timing
- Pipeline stage 1 registers xs, `pixel_y`, the active `mode`, and `video_on`. Stage 2 registers `color`, `intensity`, and blanking.
- Latency is 2 `clk` cycles from `pixel_x`/`pixel_y`/`video_on` to `color`/`intensity`. The `video_on` gating is delayed by the same 2 cycles.
- `mode`, `frame_count` and `scroll` update on the `clk` edge that samples `fs`. The pixel at (0,0) that produced `fs` is rendered with the new `mode` and `scroll`.
- A `mode_sel` change mid-frame has no effect until the next `fs`. No partial-frame pattern change is allowed.
- When `mode_sel` leaves 3 and later returns to 3, `scroll` resumes from its held value.
- `SCROLL_STEP`=0 gives static bars in mode 3.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `mode_sel`=2 → `color`=0, `intensity`=0, `mode`=0, `frame_count`=0. First (0,0) after release → `mode`=2, `frame_count`=1.
- **Mode 0 bar edges** (defaults, `video_on`=1, `pixel_y`=100), 2 cycles after each `pixel_x`:
  - 79 → `color`=0; 80 → 1; 639 → 7.
  - At `pixel_y`=240, `intensity`=1.
- **Frame-synchronous switch:** change `mode_sel` 0→1 at `pixel_y`=200 → output stays mode 0 for the rest of the frame. Next (0,0) → `mode`=1, `pixel_y`=60 gives `color`=1.
- **Scroll and wrap** (`mode_sel`=3, step 4):
  - After 3 frames, `scroll`=12; `pixel_x`=68 → `color`=1.
  - With `SCROLL_STEP`=8 and `scroll`=636, the next `fs` → `scroll`=4.
  - `pixel_x`=636 with `scroll`=4 → xs=0, `color`=0.
- **Held coordinates and counter wrap:** hold (0,0) for 5 cycles → `frame_count` increments once. 256 frames → `frame_count` returns to 0.
- **Blanking and checkerboard:**
  - `video_on`=0 → `color`=0, `intensity`=0 two cycles later.
  - Mode 2 at (32,0) → `color`=7, `intensity`=1.
  - Mode 2 at (32,32) → `color`=0.
